// File: rtl/morse_sequencer.sv
// Morse playback engine: latches a packed code word and plays its symbols with
// standard Morse timing, driving short/long tone selects and a start/busy/done
// handshake. Optional build macro MORSE_REPEAT_EN adds the repeat_req input and a
// word-gap state that loops the latched character.
// repeat_req stands in for a port called "repeat", which is a reserved word.
// N_SYM must be at least 2 so that sym_idx has a non-zero width.
module morse_sequencer #(
    parameter int unsigned N_SYM  = 5,
    parameter int unsigned UNIT_W = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic [2*N_SYM-1:0]         code,
    input  logic [UNIT_W-1:0]          unit_len,
`ifdef MORSE_REPEAT_EN
    input  logic                       repeat_req,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       tone_on,
    output logic                       short,
    output logic                       long,
    output logic [$clog2(N_SYM)-1:0]   sym_idx
);

    localparam int unsigned IDX_W = $clog2(N_SYM);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_SYM - 1);

    typedef enum logic [2:0] {
        StIdle,
        StTone,
        StGap,
        StPause,
`ifdef MORSE_REPEAT_EN
        StWgap,
`endif
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [2*N_SYM-1:0]  code_q, code_d;
    logic [UNIT_W-1:0]   unit_q, unit_d;
    logic [UNIT_W-1:0]   unit_cnt_q, unit_cnt_d;
    logic [2:0]          seg_cnt_q, seg_cnt_d;
    logic [2:0]          seg_len_q, seg_len_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                short_q, short_d;
    logic                long_q, long_d;

    logic                unit_end;
    logic                seg_end;
    logic                launch;
    logic [1:0]          launch_sym;
    logic [IDX_W:0]      next_idx;
    logic [2*N_SYM-1:0]  code_shift;
    logic [1:0]          next_sym;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            code_q     <= '0;
            unit_q     <= '0;
            unit_cnt_q <= '0;
            seg_cnt_q  <= '0;
            seg_len_q  <= '0;
            idx_q      <= '0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            unit_q     <= unit_d;
            unit_cnt_q <= unit_cnt_d;
            seg_cnt_q  <= seg_cnt_d;
            seg_len_q  <= seg_len_d;
            idx_q      <= idx_d;
            short_q    <= short_d;
            long_q     <= long_d;
        end
    end

    // Segment timing, symbol sequencing and the next-state decision.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        unit_d     = unit_q;
        unit_cnt_d = unit_cnt_q;
        seg_cnt_d  = seg_cnt_q;
        seg_len_d  = seg_len_q;
        idx_d      = idx_q;
        short_d    = short_q;
        long_d     = long_q;
        launch     = 1'b0;
        launch_sym = 2'b00;

        unit_end   = (unit_cnt_q == unit_q - 1'b1);
        seg_end    = unit_end && (seg_cnt_q == seg_len_q - 3'd1);
        next_idx   = {1'b0, idx_q} + 1'b1;
        code_shift = code_q >> {next_idx, 1'b0};
        next_sym   = code_shift[1:0];

        // Free-running unit/segment counters while a segment is being timed.
        if (unit_end) begin
            unit_cnt_d = '0;
            seg_cnt_d  = seg_cnt_q + 3'd1;
        end else begin
            unit_cnt_d = unit_cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                unit_cnt_d = '0;
                seg_cnt_d  = '0;
                if (start) begin
                    code_d     = code;
                    unit_d     = (unit_len == '0) ? UNIT_W'(1) : unit_len;
                    idx_d      = '0;
                    launch     = 1'b1;
                    launch_sym = code[1:0];
                end
            end
            StTone: begin
                if (seg_end) begin
                    state_d    = StGap;
                    seg_len_d  = 3'd1;
                    unit_cnt_d = '0;
                    seg_cnt_d  = '0;
                    short_d    = 1'b0;
                    long_d     = 1'b0;
                end
            end
            StGap, StPause: begin
                if (seg_end) begin
                    if (idx_q == LastIdx || next_sym == 2'b00) begin
`ifdef MORSE_REPEAT_EN
                        if (repeat_req) begin
                            // Gap already gave 1 unit; 6 more make the 7-unit word gap.
                            state_d    = StWgap;
                            seg_len_d  = 3'd6;
                            unit_cnt_d = '0;
                            seg_cnt_d  = '0;
                        end else begin
                            state_d = StDone;
                        end
`else
                        state_d = StDone;
`endif
                    end else begin
                        idx_d      = next_idx[IDX_W-1:0];
                        launch     = 1'b1;
                        launch_sym = next_sym;
                    end
                end
            end
`ifdef MORSE_REPEAT_EN
            StWgap: begin
                if (seg_end) begin
                    idx_d      = '0;
                    launch     = 1'b1;
                    launch_sym = code_q[1:0];
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
                idx_d   = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Start a new symbol: pick the segment type and its length in units.
        if (launch) begin
            unit_cnt_d = '0;
            seg_cnt_d  = '0;
            case (launch_sym)
                2'b01: begin
                    state_d   = StTone;
                    seg_len_d = 3'd1;
                    short_d   = 1'b1;
                end
                2'b10: begin
                    state_d   = StTone;
                    seg_len_d = 3'd3;
                    long_d    = 1'b1;
                end
                2'b11: begin
                    state_d   = StPause;
                    seg_len_d = 3'd3;
                end
                default: begin
                    state_d = StDone;
                end
            endcase
        end

        // Abort wins over any segment boundary in the same cycle.
        if (stop && state_q != StIdle) begin
            state_d    = StIdle;
            idx_d      = '0;
            unit_cnt_d = '0;
            seg_cnt_d  = '0;
            short_d    = 1'b0;
            long_d     = 1'b0;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
        short   = short_q;
        long    = long_q;
        tone_on = short_q | long_q;
        sym_idx = idx_q;
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer: each start pushes the full expected
// per-cycle output trace, built from the Morse timing rules, into a queue; a
// negedge monitor pops one entry per cycle and compares it with the outputs.
module tb_morse_sequencer;

    localparam int N_SYM  = 5;
    localparam int UNIT_W = 24;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                stop;
    logic [2*N_SYM-1:0]  code;
    logic [UNIT_W-1:0]   unit_len;
    logic                busy;
    logic                done;
    logic                tone_on;
    logic                short;
    logic                long;
    logic [2:0]          sym_idx;

    morse_sequencer #(
        .N_SYM  (N_SYM),
        .UNIT_W (UNIT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .code       (code),
        .unit_len   (unit_len),
`ifdef MORSE_REPEAT_EN
        .repeat_req (1'b0),
`endif
        .busy       (busy),
        .done       (done),
        .tone_on    (tone_on),
        .short      (short),
        .long       (long),
        .sym_idx    (sym_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       sh;
        logic       lg;
        logic       idx_care;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    int   cyc_no = 0;

    function automatic exp_t mk(input logic b, input logic d, input logic sh, input logic lg,
                                input logic care, input logic [2:0] idx);
        exp_t e;
        e.busy = b; e.done = d; e.sh = sh; e.lg = lg; e.idx_care = care; e.idx = idx;
        return e;
    endfunction

    // Reference model: expand a code word into its expected output trace.
    function automatic int push_trace(input logic [2*N_SYM-1:0] c, input int u_in);
        int u;
        int n;
        int s;
        u = (u_in == 0) ? 1 : u_in;
        n = 0;
        for (int i = 0; i < N_SYM; i++) begin
            s = (int'(c) >> (2 * i)) & 3;
            if (s == 0) break;
            if (s == 3) begin
                for (int k = 0; k < 3 * u; k++) begin
                    exp_q.push_back(mk(1, 0, 0, 0, 1, 3'(i))); n++;
                end
            end else begin
                for (int k = 0; k < ((s == 1) ? u : 3 * u); k++) begin
                    exp_q.push_back(mk(1, 0, s == 1, s == 2, 1, 3'(i))); n++;
                end
                for (int k = 0; k < u; k++) begin
                    exp_q.push_back(mk(1, 0, 0, 0, 1, 3'(i))); n++;
                end
            end
        end
        exp_q.push_back(mk(1, 1, 0, 0, 0, 3'd0)); n++;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 3'd0)); n++;
        return n;
    endfunction

    exp_t       mon_e;
    logic [7:0] mon_got;
    logic [7:0] mon_req;

    // Monitor: one comparison per cycle against the front of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc_no++;
            if (exp_q.size() > 0) mon_e = exp_q.pop_front();
            else mon_e = mk(0, 0, 0, 0, 0, 3'd0);
            mon_got = {busy, done, tone_on, short, long, mon_e.idx_care ? sym_idx : 3'd0};
            mon_req = {mon_e.busy, mon_e.done, mon_e.sh | mon_e.lg, mon_e.sh, mon_e.lg,
                       mon_e.idx_care ? mon_e.idx : 3'd0};
            total++;
            if (mon_got !== mon_req) begin
                bad++;
                $display("FAIL cycle_check cyc=%0d got(busy,done,tone,short,long,idx)=%b req=%b",
                         cyc_no, mon_got, mon_req);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop everything after the current cycle's entry (abort or reset).
    task automatic trim();
        while (exp_q.size() > 1) void'(exp_q.pop_back());
    endtask

    // One transaction; returns in the first cycle the DUT is idle again.
    task automatic run_txn(input logic [2*N_SYM-1:0] c, input logic [UNIT_W-1:0] u,
                           input int stop_cyc, input int rst_cyc, input int dup_cyc);
        int n;
        code     = c;
        unit_len = u;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = push_trace(c, int'(u));
        for (int cyc = 1; cyc <= n - 1; cyc++) begin
            code     = 10'($urandom);
            unit_len = UNIT_W'($urandom_range(0, 7));
            if (cyc == stop_cyc) begin
                trim();
                exp_q.push_back(mk(0, 0, 0, 0, 1, 3'd0));
                stop = 1'b1;
                tick();
                stop = 1'b0;
                return;
            end
            if (cyc == rst_cyc) begin
                trim();
                for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 0, 0, 0, 1, 3'd0));
                reset = 1'b0;
                tick(); tick(); tick();
                reset = 1'b1;
                return;
            end
            start = (cyc == dup_cyc);
            tick();
        end
        start = 1'b0;
    endtask

    function automatic logic [2*N_SYM-1:0] rand_code();
        logic [2*N_SYM-1:0] c;
        for (int i = 0; i < N_SYM; i++) begin
            c[2*i +: 2] = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        end
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int rc;
        int dc;
        reset    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        code     = '0;
        unit_len = '0;
        tick();
        // Reset state: outputs and index all zero while reset is held.
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 0, 0, 0, 1, 3'd0));
        mon_en = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();

        run_txn(10'h009, 24'd2, -1, -1, -1);
        run_txn(10'h000, 24'd5, -1, -1, -1);
        run_txn(10'h3FF, 24'd0, -1, -1, -1);
        run_txn(10'h155, 24'd1, -1, -1, 4);
        run_txn(10'h009, 24'd2, 6, -1, -1);
        run_txn(10'h155, 24'd1, -1, -1, -1);
        run_txn(10'h009, 24'd2, -1, 5, -1);
        run_txn(10'h00E, 24'd1, -1, -1, -1);

        for (int t = 0; t < 150; t++) begin
            sc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 40)) : -1;
            rc = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 40)) : -1;
            dc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : -1;
            run_txn(rand_code(), UNIT_W'($urandom_range(0, 4)), sc, rc, dc);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
        end

        tick(); tick(); tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain left=%0d req=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Parametrised Morse playback engine between the audio register stage and the tone generator. It latches a packed code word of N_SYM two-bit symbols and plays them with standard Morse timing: dot 1 unit, dash 3 units, 1-unit inter-symbol gap. It drives `short`/`long` tone-select levels for the sound module, and it exposes a start/busy/done handshake so the processor can sequence characters.

## Interface
- N_SYM, 5, symbols per code word; code width is 2*N_SYM.
- UNIT_W, 24, width of the unit-length counter; unit_len is in clk cycles.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  start request; sampled only in IDLE.
- stop  in  1  synchronous abort; has priority over everything except reset.
- code  in  2*N_SYM  packed symbols; symbol 0 is in bits [1:0] and plays first. 00 means end, 01 dot, 10 dash, 11 pause.
- unit_len  in  UNIT_W  unit length in cycles; a value of 0 is treated as 1.
- repeat  in  1  loop request; present only with MORSE_REPEAT_EN.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- tone_on  out  1  tone active.
- short  out  1  high during a dot tone.
- long  out  1  high during a dash tone.
- sym_idx  out  $clog2(N_SYM)  index of the symbol currently being played.

## Operation
- States are IDLE, TONE, GAP, PAUSE, DONE, and WGAP (WGAP exists only with the macro).
- IDLE
  - On start=1, latch `code` and `unit_len` (0 becomes 1) and set sym_idx=0. Decode symbol 0.
  - 01 goes to TONE for 1 unit; 10 goes to TONE for 3 units; 11 goes to PAUSE for 3 units; 00 goes to DONE.
- TONE: tone_on=1, with short or long chosen by the symbol. When the duration expires, go to GAP for 1 unit.
- GAP and PAUSE: silent. On expiry, increment sym_idx and decode the next symbol as in IDLE.
  - If sym_idx was N_SYM-1, or the next symbol is 00, this is the end of the character and the block goes to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- stop=1 in any non-IDLE state: the next cycle is IDLE with all outputs 0. No done pulse is produced.
- Inputs `code` and `unit_len` are ignored while busy. A start received while busy is ignored and is not queued.
- Duration logic: a unit counter runs 0..unit_len-1, and a 3-bit unit count runs 0..k-1 with k ∈ {1,3} (or 6 for WGAP).
- short, long and tone_on are registered outputs and are mutually consistent: tone_on = short | long.

## Timing
- Reset values: all outputs 0, state IDLE, latched code 0, counters 0.
- start at cycle 0: busy and the first tone (or DONE) appear at cycle 1.
- busy is high from cycle 1 through the DONE cycle inclusive.
- Tone length is exactly U or 3U cycles, gap is U cycles and pause is 3U cycles, where U is the latched unit length. Consecutive segments have no dead cycles between them.
- DONE follows the last GAP or PAUSE cycle immediately.
- An all-00 code gives done=busy=1 at cycle 1 only.
- If stop and the end of a segment coincide, stop wins.
- If reset is asserted mid-tone, outputs are 0 on the next cycle.

## Configuration
- MORSE_REPEAT_EN defined:
  - Adds the `repeat` input. repeat is sampled at the end-of-character decision point.
  - If repeat=1, enter WGAP for 6U cycles (7U of silence in total, including the preceding gap), then replay from symbol 0 with the latched code. No done pulse and busy stays high.
  - If repeat=0, behaviour is normal DONE.
  - stop aborts WGAP.
- MORSE_REPEAT_EN undefined: no `repeat` port and no WGAP state. Every sequence ends in DONE.

## Test plan
- Reset: hold reset=0 for 3 cycles mid-tone -> all outputs 0 on the next cycle; IDLE after release.
- code=10'h009 (dot, dash, end), unit_len=2, start at cycle 0:
  - short=1 on cycles 1-2; silent 3-4; long=1 on 5-10; silent 11-12.
  - done=1 at cycle 13 and busy low at 14.
- code=10'h000 -> done=busy=1 at cycle 1 only, tone_on never high. code=10'h3FF, unit_len=0 (5 pauses, U=1) -> silent cycles 1-15, done at 16.
- code=10'h155 (5 dots), unit_len=1 -> tone on odd cycles 1..9, sym_idx 0..4, done at cycle 11. A start pulse at cycle 4 is ignored.
- stop=1 at cycle 6 during the dash in the 10'h009 run -> cycle 7 in IDLE with all outputs 0 and no done pulse. A new start is accepted at cycle 7.
- With MORSE_REPEAT_EN, code=10'h001, U=1, repeat=1 -> tone at cycle 1, silent 2-8, tone at cycle 9. Dropping repeat before cycle 10 -> done at cycle 11.
